mem_port_arbiter: RTL and testbench

Sequences the multi-cycle core's single shared memory port between the instruction-fetch requester and the load/store data requester. Sits between the fetch/execute stage and the memory model. Accepts one level-held request at a time, issues it to memory, and returns read data with a one-cycle ready pulse. A watchdog terminates any access that memory never acknowledges.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_timeout_ctr.sv | 37 +++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM state and access owner.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Watchdog counter for a pending memory access. Counts Busy cycles without
// an acknowledge; expired rises once TIMEOUT_CYCLES such cycles have
// elapsed, so the forced completion lands TIMEOUT_CYCLES+1 edges after the
// grant. A zero TIMEOUT_CYCLES removes the counter entirely.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_ctr_inputs;
      assign unused_ctr_inputs = ^{clk, rst, clear, enable};
      assign expired = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
      logic [CW-1:0] cnt;

      // Count stalled Busy cycles; hold at the limit so the count never wraps.
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          cnt <= '0;
        end else if (enable && !expired) begin
          cnt <= cnt + 1'b1;
        end
      end

      assign expired = (cnt == CW'(TIMEOUT_CYCLES));
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and load/store.
// Data requests have fixed priority over fetch. Each access runs
// Idle -> Busy -> Resp -> Idle, and every output is a register.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read_instr_i,
  input  logic [ADDR_WIDTH-1:0]   pc_i,
  output logic [DATA_WIDTH-1:0]   instr_o,
  output logic                    instr_ready_o,
  output logic                    instr_err_o,
  input  logic                    data_req_i,
  input  logic                    data_we_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    data_ready_o,
  output logic                    data_err_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_ready_i
);

  arb_state_e state;
  arb_owner_e owner;
  logic       tmo_expired;
  logic       tmo_clear;
  logic       tmo_enable;

  // The counter is held clear while idle, so it starts from zero at grant.
  assign tmo_clear  = (state == ST_IDLE);
  assign tmo_enable = (state == ST_BUSY) && !mem_ready_i;

  mem_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expired(tmo_expired)
  );

  // Arbitration FSM with registered request fields and response pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      owner         <= OWN_INSTR;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      mem_be_o      <= '0;
      instr_o       <= '0;
      instr_ready_o <= 1'b0;
      instr_err_o   <= 1'b0;
      data_rdata_o  <= '0;
      data_ready_o  <= 1'b0;
      data_err_o    <= 1'b0;
    end else begin
      // Ready/err are single-cycle pulses; only the Busy exit raises them.
      instr_ready_o <= 1'b0;
      instr_err_o   <= 1'b0;
      data_ready_o  <= 1'b0;
      data_err_o    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (data_req_i) begin
            owner       <= OWN_DATA;
            mem_req_o   <= 1'b1;
            mem_we_o    <= data_we_i;
            mem_addr_o  <= data_addr_i;
            mem_wdata_o <= data_wdata_i;
            mem_be_o    <= data_be_i;
            state       <= ST_BUSY;
          end else if (read_instr_i) begin
            owner       <= OWN_INSTR;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= pc_i;
            mem_wdata_o <= '0;
            mem_be_o    <= '1;
            state       <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          // An acknowledge on the expiry cycle still counts as a clean finish.
          if (mem_ready_i) begin
            mem_req_o <= 1'b0;
            state     <= ST_RESP;
            if (owner == OWN_DATA) begin
              data_rdata_o <= mem_rdata_i;
              data_ready_o <= 1'b1;
            end else begin
              instr_o       <= mem_rdata_i;
              instr_ready_o <= 1'b1;
            end
          end else if (tmo_expired) begin
            mem_req_o <= 1'b0;
            state     <= ST_RESP;
            if (owner == OWN_DATA) begin
              data_rdata_o <= '0;
              data_ready_o <= 1'b1;
              data_err_o   <= 1'b1;
            end else begin
              instr_o       <= '0;
              instr_ready_o <= 1'b1;
              instr_err_o   <= 1'b1;
            end
          end
        end

        ST_RESP: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference
// model and a per-cycle compare process.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int T  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          read_instr_i;
  logic [AW-1:0] pc_i;
  logic [DW-1:0] instr_o;
  logic          instr_ready_o;
  logic          instr_err_o;
  logic          data_req_i;
  logic          data_we_i;
  logic [AW-1:0] data_addr_i;
  logic [DW-1:0] data_wdata_i;
  logic [BW-1:0] data_be_i;
  logic [DW-1:0] data_rdata_o;
  logic          data_ready_o;
  logic          data_err_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [BW-1:0] mem_be_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_ready_i;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .read_instr_i (read_instr_i),
    .pc_i         (pc_i),
    .instr_o      (instr_o),
    .instr_ready_o(instr_ready_o),
    .instr_err_o  (instr_err_o),
    .data_req_i   (data_req_i),
    .data_we_i    (data_we_i),
    .data_addr_i  (data_addr_i),
    .data_wdata_i (data_wdata_i),
    .data_be_i    (data_be_i),
    .data_rdata_o (data_rdata_o),
    .data_ready_o (data_ready_o),
    .data_err_o   (data_err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_be_o     (mem_be_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ready_i  (mem_ready_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory responder: acknowledges mem_lat cycles into an access (0 = never).
  int            mem_lat  = 1;
  logic [DW-1:0] mem_word = '0;
  bit            stray    = 1'b0;
  int            bcnt     = 0;

  always @(posedge clk) begin
    #1;
    if (mem_req_o) bcnt++;
    else bcnt = 0;
    mem_ready_i = (mem_req_o && mem_lat != 0 && bcnt == mem_lat) || stray;
    mem_rdata_i = mem_ready_i ? mem_word : 32'hA5A5_5A5A;
  end

  // Reference model: one outstanding transaction with a grant cycle and a
  // completion cycle; arbitration reopens two cycles after completion.
  int            cyc      = 0;
  bit            started  = 1'b0;
  bit            m_act    = 1'b0;
  int            m_g      = 0;
  int            m_d      = -1;
  int            m_free   = 0;
  bit            m_own_d  = 1'b0;
  bit            m_we     = 1'b0;
  bit            m_err    = 1'b0;
  bit            m_rstout = 1'b0;
  logic [AW-1:0] m_addr   = '0;
  logic [DW-1:0] m_wdata  = '0;
  logic [BW-1:0] m_be     = '0;
  logic [DW-1:0] m_instr  = '0;
  logic [DW-1:0] m_rdata  = '0;

  always @(posedge clk) begin
    cyc++;
    m_rstout = 1'b0;
    if (rst) begin
      m_act = 1'b0; m_d = -1; m_free = cyc + 1;
      m_instr = '0; m_rdata = '0; m_rstout = 1'b1; started = 1'b1;
    end else begin
      if (m_act && m_d < 0) begin
        if (mem_ready_i) begin
          m_d = cyc; m_err = 1'b0;
          if (m_own_d) m_rdata = mem_rdata_i;
          else m_instr = mem_rdata_i;
        end else if (T > 0 && cyc - m_g == T + 1) begin
          m_d = cyc; m_err = 1'b1;
          if (m_own_d) m_rdata = '0;
          else m_instr = '0;
        end
      end else if (m_act && cyc == m_d + 1) begin
        m_act = 1'b0; m_free = cyc + 1;
      end
      if (!m_act && cyc >= m_free) begin
        if (data_req_i) begin
          m_act = 1'b1; m_g = cyc; m_d = -1; m_own_d = 1'b1;
          m_we = data_we_i; m_addr = data_addr_i; m_wdata = data_wdata_i; m_be = data_be_i;
        end else if (read_instr_i) begin
          m_act = 1'b1; m_g = cyc; m_d = -1; m_own_d = 1'b0;
          m_we = 1'b0; m_addr = pc_i; m_wdata = '0; m_be = '1;
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge after reset.
  bit busy_e, pulse_e;
  always @(negedge clk) begin
    if (started) begin
      busy_e  = m_act && m_d < 0;
      pulse_e = m_act && m_d == cyc;
      chk("mem_req", mem_req_o, busy_e);
      chk("instr_ready", instr_ready_o, pulse_e && !m_own_d);
      chk("instr_err", instr_err_o, pulse_e && !m_own_d && m_err);
      chk("data_ready", data_ready_o, pulse_e && m_own_d);
      chk("data_err", data_err_o, pulse_e && m_own_d && m_err);
      chk("instr_o", instr_o, m_instr);
      if (busy_e) begin
        chk("mem_we", mem_we_o, m_we);
        chk("mem_addr", mem_addr_o, m_addr);
        chk("mem_be", mem_be_o, m_be);
        if (m_we) chk("mem_wdata", mem_wdata_o, m_wdata);
      end
      if (pulse_e && m_own_d && !m_we) chk("data_rdata", data_rdata_o, m_rdata);
      if (m_rstout) begin
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_mem_be", mem_be_o, 0);
        chk("rst_data_rdata", data_rdata_o, 0);
      end
    end
  end

  function automatic bit sel(input int w);
    case (w)
      0:       return instr_ready_o;
      1:       return data_ready_o;
      default: return mem_req_o;
    endcase
  endfunction

  // Wait (bounded) for instr_ready (0), data_ready (1) or mem_req (2).
  task automatic wait_for(input int w, input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sel(w) && n < 50);
    n_cmp++;
    if (!sel(w)) begin
      n_bad++;
      $display("FAIL %s wait: got 0 expected 1 within 50 cycles", nm);
    end
  endtask

  int n;

  initial begin
    rst = 1'b1; read_instr_i = 1'b0; pc_i = '0; data_req_i = 1'b0; data_we_i = 1'b0;
    data_addr_i = '0; data_wdata_i = '0; data_be_i = '0;
    mem_ready_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(negedge clk);
    chk("reset_mem_req", mem_req_o, 0);
    chk("reset_instr_o", instr_o, 0);
    chk("reset_ready", {instr_ready_o, data_ready_o, instr_err_o, data_err_o}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single fetch, memory acknowledges in the first Busy cycle.
    mem_lat = 1; mem_word = 32'h0050_0093;
    read_instr_i = 1'b1; pc_i = 32'h100;
    wait_for(2, "fetch_grant", n);
    chk("fetch_addr", mem_addr_o, 32'h100);
    chk("fetch_we", mem_we_o, 0);
    chk("fetch_be", mem_be_o, 4'hF);
    wait_for(0, "fetch_ready", n);
    chk("fetch_latency", n, 1);
    chk("fetch_instr", instr_o, 32'h0050_0093);
    read_instr_i = 1'b0;
    @(negedge clk);
    chk("fetch_pulse_width", instr_ready_o, 0);

    // Simultaneous fetch and load: load first, fetch two cycles after its pulse.
    @(negedge clk);
    mem_word = 32'h1122_3344;
    read_instr_i = 1'b1; pc_i = 32'h104;
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h2000; data_be_i = 4'h0;
    wait_for(2, "prio_grant", n);
    chk("prio_addr", mem_addr_o, 32'h2000);
    wait_for(1, "prio_data_ready", n);
    chk("prio_rdata", data_rdata_o, 32'h1122_3344);
    chk("prio_instr_idle", instr_ready_o, 0);
    data_req_i = 1'b0; mem_word = 32'h5566_7788;
    wait_for(2, "prio_fetch_grant", n);
    chk("prio_fetch_gap", n, 2);
    chk("prio_fetch_addr", mem_addr_o, 32'h104);
    wait_for(0, "prio_fetch_ready", n);
    chk("prio_fetch_instr", instr_o, 32'h5566_7788);
    read_instr_i = 1'b0;

    // Store with partial byte enables.
    @(negedge clk);
    mem_lat = 2;
    data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h3004;
    data_wdata_i = 32'hDEAD_BEEF; data_be_i = 4'b0011;
    wait_for(2, "store_grant", n);
    chk("store_we", mem_we_o, 1);
    chk("store_addr", mem_addr_o, 32'h3004);
    chk("store_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    chk("store_be", mem_be_o, 4'b0011);
    wait_for(1, "store_ready", n);
    chk("store_side", {instr_ready_o, instr_err_o, data_err_o}, 0);
    data_req_i = 1'b0; data_we_i = 1'b0;

    // Timeout: memory never acknowledges.
    @(negedge clk);
    mem_lat = 0; mem_word = 32'h7777_7777;
    data_req_i = 1'b1; data_addr_i = 32'h4000;
    wait_for(2, "tmo_grant", n);
    wait_for(1, "tmo_ready", n);
    chk("tmo_latency", n, 5);
    chk("tmo_err", data_err_o, 1);
    chk("tmo_rdata", data_rdata_o, 0);
    data_req_i = 1'b0;

    // Next request after a timeout completes normally.
    mem_lat = 2; mem_word = 32'hCAFE_F00D;
    read_instr_i = 1'b1; pc_i = 32'h108;
    wait_for(0, "post_tmo_ready", n);
    chk("post_tmo_instr", instr_o, 32'hCAFE_F00D);
    chk("post_tmo_err", instr_err_o, 0);
    read_instr_i = 1'b0;

    // Acknowledge on the expiry cycle wins with no error.
    @(negedge clk);
    mem_lat = 5; mem_word = 32'h0BAD_CAFE;
    data_req_i = 1'b1; data_addr_i = 32'h5000;
    wait_for(1, "tie_ready", n);
    chk("tie_latency", n, 6);
    chk("tie_err", data_err_o, 0);
    chk("tie_rdata", data_rdata_o, 32'h0BAD_CAFE);
    data_req_i = 1'b0;

    // Stray acknowledge while idle is ignored.
    repeat (2) @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a Busy access.
    mem_lat = 0;
    read_instr_i = 1'b1; pc_i = 32'h200;
    wait_for(2, "rstb_grant", n);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstb_mem_req", mem_req_o, 0);
    chk("rstb_ready", {instr_ready_o, data_ready_o, instr_err_o, data_err_o}, 0);
    chk("rstb_addr", mem_addr_o, 0);
    chk("rstb_instr", instr_o, 0);
    rst = 1'b0;
    mem_lat = 1; mem_word = 32'h1234_5678;
    wait_for(0, "rstb_refetch", n);
    chk("rstb_refetch_instr", instr_o, 32'h1234_5678);
    read_instr_i = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
